// File: rtl/psa_accum_ctrl.sv
// Multi-cycle reducer: sums a stream of packed 4x4-bit operands with per-lane saturating add.
// Optional sticky per-lane saturation flags when PSA_ACCUM_SAT_FLAGS_EN is defined.

module psa_lane_sat #(
  parameter int VEC_W = 4
) (
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic [VEC_W-1:0] y
`ifdef PSA_ACCUM_SAT_FLAGS_EN
  ,
  output logic             ovf
`endif
);
  logic [VEC_W-1:0] s;
  logic             pos_ovf, neg_ovf;

  assign s       = a + b;
  assign pos_ovf = ~a[VEC_W-1] & ~b[VEC_W-1] &  s[VEC_W-1];
  assign neg_ovf =  a[VEC_W-1] &  b[VEC_W-1] & ~s[VEC_W-1];

  always_comb begin
    y = s;
    if (pos_ovf)      y = {1'b0, {(VEC_W-1){1'b1}}};
    else if (neg_ovf) y = {1'b1, {(VEC_W-1){1'b0}}};
  end

`ifdef PSA_ACCUM_SAT_FLAGS_EN
  assign ovf = pos_ovf | neg_ovf;
`endif
endmodule

module psa_accum_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  count,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic [3:0]  sat_flags
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  rem_q, rem_d;

  logic [NUM_LANES-1:0][VEC_W-1:0] acc_lanes, in_lanes, sum_lanes;

  assign acc_lanes = acc_q;
  assign in_lanes  = in_data;

`ifdef PSA_ACCUM_SAT_FLAGS_EN
  logic [NUM_LANES-1:0] lane_ovf;
  logic [NUM_LANES-1:0] sat_q, sat_d;
`endif

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    psa_lane_sat #(.VEC_W(VEC_W)) u_lane (
      .a   (acc_lanes[k]),
      .b   (in_lanes[k]),
      .y   (sum_lanes[k])
`ifdef PSA_ACCUM_SAT_FLAGS_EN
      ,
      .ovf (lane_ovf[k])
`endif
    );
  end

  logic accept;
  assign accept = (state_q == ACCUM) && in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
`ifdef PSA_ACCUM_SAT_FLAGS_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        acc_d = '0;
`ifdef PSA_ACCUM_SAT_FLAGS_EN
        sat_d = '0;
`endif
        if (count != 4'd0) begin
          rem_d   = count;
          state_d = ACCUM;
        end else begin
          state_d = DONE;
        end
      end
      ACCUM: if (accept) begin
        acc_d = sum_lanes;
        rem_d = rem_q - 4'd1;
`ifdef PSA_ACCUM_SAT_FLAGS_EN
        sat_d = sat_q | lane_ovf;
`endif
        if (rem_q == 4'd1) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

`ifdef PSA_ACCUM_SAT_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= '0;
    else        sat_q <= sat_d;
  end
  assign sat_flags = sat_q;
`else
  assign sat_flags = 4'b0000;
`endif

  // All outputs decode registered state only; no input reaches an output combinationally.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign busy      = (state_q != IDLE);
endmodule
